mc_control: RTL and testbench

MC_CONTROL -- requirements
Module: mc_control

---
 rtl/mc_control.sv | 258 +++++++++++++++++++++++++
 tb/tb_mc_control.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mc_control.sv
// mc_control: multi-cycle processor control unit (Moore FSM).
//
// Sequences instruction fetch, decode, execute, memory access, write-back
// and branch resolution for a small multi-cycle datapath.
//
// Ports
//   clk          single clock, rising edge
//   reset_n      synchronous active-low reset
//   opcode       instruction bits [31:26] from the instruction register
//   funct        instruction bits [5:0]
//   zflag/nflag  registered ALU zero/negative status (used in BRANCH only)
//   mem_ready    memory access completes this cycle
//   pcwrite, irwrite, iord, memread, memwrite, regwrite, regdest,
//   memtoreg, alusrc, link           datapath strobes and selects
//   aluop        00 add, 01 subtract, 10 funct-decoded
//   pcsrc        00 ALU (PC+4), 01 branch target, 10 rs, 11 memory data
//   state        current FSM state code
//   illegal      undecoded instruction trapped
//
// Build option: define ILLEGAL_TRAP_EN to trap undecoded instructions in
// TRAP (held until reset). Without it they retire as a no-op and illegal=0.
//
// state  | meaning
// -------+--------------------------------------------------------------
// FETCH  | read instruction; wait for mem_ready, then load IR and PC+4
// DECODE | classify the freshly loaded instruction
// EXEC   | ALU operation / address computation
// MEM    | data memory access; held until mem_ready
// WB     | register file write-back
// BRANCH | resolve branch / jump, optional link write
// TRAP   | undecoded instruction, held until reset

module mc_control (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zflag,
    input  logic       nflag,
    input  logic       mem_ready,
    output logic       pcwrite,
    output logic       irwrite,
    output logic       iord,
    output logic       memread,
    output logic       memwrite,
    output logic       regwrite,
    output logic       regdest,
    output logic       memtoreg,
    output logic       alusrc,
    output logic       link,
    output logic [1:0] aluop,
    output logic [1:0] pcsrc,
    output logic [3:0] state,
    output logic       illegal
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC   = 4'd2,
        S_MEM    = 4'd3,
        S_WB     = 4'd4,
        S_BRANCH = 4'd5,
        S_TRAP   = 4'd6
    } state_t;

    typedef enum logic [3:0] {
        C_R, C_LW, C_SW, C_BEQ, C_BMN, C_BZ, C_BRZ, C_JMOR, C_JALM, C_BAD
    } iclass_t;

    function automatic iclass_t classify(input logic [5:0] op, input logic [5:0] fn);
        iclass_t c;
        case (op)
            6'b000000: begin
                case (fn)
                    6'b010010: c = C_BRZ;
                    6'b100001: c = C_JMOR;
                    default:   c = C_R;
                endcase
            end
            6'b100011: c = C_LW;
            6'b101011: c = C_SW;
            6'b000100: c = C_BEQ;
            6'b010101: c = C_BMN;
            6'b011000: c = C_BZ;
            6'b010011: c = C_JALM;
            default:   c = C_BAD;
        endcase
        return c;
    endfunction

    state_t     state_q;
    state_t     state_d;
    logic       in_reset_q;
    logic [5:0] op_q;
    logic [5:0] fn_q;
    iclass_t    cls_dec;
    iclass_t    cls_q;

    // DECODE steers on the live IR; later states use the copy captured in
    // DECODE so the IR may change underneath without affecting sequencing.
    assign cls_dec = classify(opcode, funct);
    assign cls_q   = classify(op_q, fn_q);

    // in_reset_q keeps every output low for the cycle following a reset edge
    // (FETCH would otherwise raise memread); FETCH proper starts after release.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_FETCH;
            in_reset_q <= 1'b1;
            op_q       <= 6'd0;
            fn_q       <= 6'd0;
        end else begin
            state_q    <= state_d;
            in_reset_q <= 1'b0;
            if (state_q == S_DECODE) begin
                op_q <= opcode;
                fn_q <= funct;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        pcwrite  = 1'b0;
        irwrite  = 1'b0;
        iord     = 1'b0;
        memread  = 1'b0;
        memwrite = 1'b0;
        regwrite = 1'b0;
        regdest  = 1'b0;
        memtoreg = 1'b0;
        alusrc   = 1'b0;
        link     = 1'b0;
        aluop    = 2'b00;
        pcsrc    = 2'b00;
        illegal  = 1'b0;

        if (in_reset_q) begin
            state_d = S_FETCH;
        end else begin
            case (state_q)
                S_FETCH: begin
                    memread = 1'b1;
                    if (mem_ready) begin
                        irwrite = 1'b1;
                        pcwrite = 1'b1;
                        state_d = S_DECODE;
                    end
                end

                S_DECODE: begin
                    case (cls_dec)
                        C_BEQ, C_BZ, C_BRZ: state_d = S_BRANCH;
`ifdef ILLEGAL_TRAP_EN
                        C_BAD:              state_d = S_TRAP;
`else
                        C_BAD:              state_d = S_FETCH;
`endif
                        default:            state_d = S_EXEC;
                    endcase
                end

                S_EXEC: begin
                    case (cls_q)
                        C_R: begin
                            aluop   = 2'b10;
                            state_d = S_WB;
                        end
                        C_LW, C_SW, C_BMN, C_JALM: begin
                            alusrc  = 1'b1;
                            state_d = S_MEM;
                        end
                        // ALU passes rs through as the memory address
                        C_JMOR:  state_d = S_MEM;
                        default: state_d = S_FETCH;
                    endcase
                end

                S_MEM: begin
                    case (cls_q)
                        C_LW: begin
                            memread = 1'b1;
                            iord    = 1'b1;
                            if (mem_ready) state_d = S_WB;
                        end
                        C_SW: begin
                            memwrite = 1'b1;
                            iord     = 1'b1;
                            if (mem_ready) state_d = S_FETCH;
                        end
                        C_BMN, C_JMOR, C_JALM: begin
                            memread = 1'b1;
                            if (mem_ready) state_d = S_BRANCH;
                        end
                        default: state_d = S_FETCH;
                    endcase
                end

                S_WB: begin
                    case (cls_q)
                        C_R: begin
                            regwrite = 1'b1;
                            regdest  = 1'b1;
                        end
                        C_LW: begin
                            regwrite = 1'b1;
                            memtoreg = 1'b1;
                        end
                        default: ;
                    endcase
                    state_d = S_FETCH;
                end

                S_BRANCH: begin
                    case (cls_q)
                        C_BEQ, C_BZ: begin
                            aluop   = 2'b01;
                            pcsrc   = 2'b01;
                            pcwrite = zflag;
                        end
                        C_BRZ: begin
                            pcsrc   = 2'b10;
                            pcwrite = zflag;
                        end
                        C_BMN: begin
                            pcsrc   = 2'b11;
                            pcwrite = nflag;
                        end
                        C_JMOR, C_JALM: begin
                            pcsrc    = 2'b11;
                            pcwrite  = 1'b1;
                            regwrite = 1'b1;
                            link     = 1'b1;
                            regdest  = (cls_q == C_JMOR);
                        end
                        default: ;
                    endcase
                    state_d = S_FETCH;
                end

                S_TRAP: begin
`ifdef ILLEGAL_TRAP_EN
                    illegal = 1'b1;
                    state_d = S_TRAP;
`else
                    state_d = S_FETCH;
`endif
                end

                default: state_d = S_FETCH;
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_mc_control.sv
// Testbench for mc_control: directed scenarios plus randomized instruction
// stream, each cycle compared against an instruction-level reference model.
// Honours ILLEGAL_TRAP_EN the same way as the design build.

module tb_mc_control;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zflag = 1'b0;
    logic       nflag = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pcwrite, irwrite, iord, memread, memwrite;
    logic       regwrite, regdest, memtoreg, alusrc, link;
    logic [1:0] aluop, pcsrc;
    logic [3:0] state;
    logic       illegal;

    int checks = 0;
    int errors = 0;

    mc_control dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct),
        .zflag(zflag), .nflag(nflag), .mem_ready(mem_ready),
        .pcwrite(pcwrite), .irwrite(irwrite), .iord(iord), .memread(memread),
        .memwrite(memwrite), .regwrite(regwrite), .regdest(regdest),
        .memtoreg(memtoreg), .alusrc(alusrc), .link(link), .aluop(aluop),
        .pcsrc(pcsrc), .state(state), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // observed vector: {state, 10 strobes, aluop, pcsrc, illegal}
    logic [18:0] obs;
    assign obs = {state, pcwrite, irwrite, iord, memread, memwrite, regwrite,
                  regdest, memtoreg, alusrc, link, aluop, pcsrc, illegal};

    localparam logic [14:0] PCW  = 15'h4000;
    localparam logic [14:0] IRW  = 15'h2000;
    localparam logic [14:0] IORD = 15'h1000;
    localparam logic [14:0] MR   = 15'h0800;
    localparam logic [14:0] MW   = 15'h0400;
    localparam logic [14:0] RW   = 15'h0200;
    localparam logic [14:0] RD   = 15'h0100;
    localparam logic [14:0] MTR  = 15'h0080;
    localparam logic [14:0] ASRC = 15'h0040;
    localparam logic [14:0] LNK  = 15'h0020;
    localparam logic [14:0] ASUB = 15'h0008;
    localparam logic [14:0] AFN  = 15'h0010;
    localparam logic [14:0] PBR  = 15'h0002;
    localparam logic [14:0] PRS  = 15'h0004;
    localparam logic [14:0] PMEM = 15'h0006;
    localparam logic [14:0] ILL  = 15'h0001;

    function automatic logic [18:0] mk(input logic [3:0] st, input logic [14:0] b);
        return {st, b};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // 0 R, 1 lw, 2 sw, 3 beq, 4 bmn, 5 bz, 6 brz, 7 jmor, 8 jalm, 9 undecoded
    function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'b000000) begin
            if (fn == 6'b010010) return 6;
            if (fn == 6'b100001) return 7;
            return 0;
        end
        if (op == 6'b100011) return 1;
        if (op == 6'b101011) return 2;
        if (op == 6'b000100) return 3;
        if (op == 6'b010101) return 4;
        if (op == 6'b011000) return 5;
        if (op == 6'b010011) return 8;
        return 9;
    endfunction

    // one cycle: drive inputs at negedge, compare outputs 1 time unit later
    task automatic step(input logic mr, input logic z, input logic n,
                        input logic [18:0] e, input string tag);
        @(negedge clk);
        mem_ready = mr;
        zflag     = z;
        nflag     = n;
        #1;
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, e);
        end
    endtask

    task automatic do_reset(input int n);
        reset_n = 1'b0;
        for (int i = 0; i < n; i++) step(rb(), rb(), rb(), 19'd0, "reset");
        reset_n = 1'b1;
    endtask

    task automatic mem_phase(input int wm, input logic [14:0] b, input string tag);
        for (int i = 0; i < wm; i++) step(1'b0, rb(), rb(), mk(4'd3, b), tag);
        step(1'b1, rb(), rb(), mk(4'd3, b), tag);
    endtask

    // fetch + decode, then scramble the IR after DECODE has been left
    task automatic front_end(input logic [5:0] op, input logic [5:0] fn, input int wf);
        opcode = op;
        funct  = fn;
        for (int i = 0; i < wf; i++) step(1'b0, rb(), rb(), mk(4'd0, MR), "fetch_wait");
        step(1'b1, rb(), rb(), mk(4'd0, MR | IRW | PCW), "fetch_done");
        step(rb(), rb(), rb(), mk(4'd1, 15'd0), "decode");
        @(posedge clk);
        #1;
        opcode = 6'($urandom);
        funct  = 6'($urandom);
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int wf, input int wm, input logic z, input logic n);
        int c;
        c = classify(op, fn);
        front_end(op, fn, wf);
        case (c)
            0: begin
                step(rb(), rb(), rb(), mk(4'd2, AFN), "r_exec");
                step(rb(), rb(), rb(), mk(4'd4, RW | RD), "r_wb");
            end
            1: begin
                step(rb(), rb(), rb(), mk(4'd2, ASRC), "lw_exec");
                mem_phase(wm, MR | IORD, "lw_mem");
                step(rb(), rb(), rb(), mk(4'd4, RW | MTR), "lw_wb");
            end
            2: begin
                step(rb(), rb(), rb(), mk(4'd2, ASRC), "sw_exec");
                mem_phase(wm, MW | IORD, "sw_mem");
            end
            3, 5: step(rb(), z, n, mk(4'd5, ASUB | PBR | (z ? PCW : 15'd0)), "beq_bz_branch");
            6:    step(rb(), z, n, mk(4'd5, PRS | (z ? PCW : 15'd0)), "brz_branch");
            4: begin
                step(rb(), rb(), rb(), mk(4'd2, ASRC), "bmn_exec");
                mem_phase(wm, MR, "bmn_mem");
                step(rb(), z, n, mk(4'd5, PMEM | (n ? PCW : 15'd0)), "bmn_branch");
            end
            7: begin
                step(rb(), rb(), rb(), mk(4'd2, 15'd0), "jmor_exec");
                mem_phase(wm, MR, "jmor_mem");
                step(rb(), z, n, mk(4'd5, PMEM | PCW | RW | LNK | RD), "jmor_branch");
            end
            8: begin
                step(rb(), rb(), rb(), mk(4'd2, ASRC), "jalm_exec");
                mem_phase(wm, MR, "jalm_mem");
                step(rb(), z, n, mk(4'd5, PMEM | PCW | RW | LNK), "jalm_branch");
            end
            default: begin
`ifdef ILLEGAL_TRAP_EN
                for (int i = 0; i < 10; i++)
                    step(rb(), rb(), rb(), mk(4'd6, ILL), "trap_hold");
                do_reset(2);
`endif
            end
        endcase
    endtask

    task automatic sw_abort();
        front_end(6'b101011, 6'($urandom), 0);
        step(rb(), rb(), rb(), mk(4'd2, ASRC), "swab_exec");
        step(1'b0, rb(), rb(), mk(4'd3, MW | IORD), "swab_mem");
        step(1'b0, rb(), rb(), mk(4'd3, MW | IORD), "swab_mem");
        do_reset(2);
    endtask

    initial begin
        logic [5:0] op;
        logic [5:0] fn;
        int k;

        // reset held from time 0, two cycles checked all-zero
        for (int i = 0; i < 2; i++) step(1'b1, rb(), rb(), 19'd0, "init_reset");
        reset_n = 1'b1;

        run_instr(6'b100011, 6'd7, 1, 3, 1'b0, 1'b0);
        run_instr(6'b000100, 6'd0, 0, 0, 1'b1, 1'b0);
        run_instr(6'b000100, 6'd0, 0, 0, 1'b0, 1'b1);
        run_instr(6'b010011, 6'd5, 0, 1, 1'b0, 1'b0);
        run_instr(6'b000000, 6'b100001, 0, 0, 1'b0, 1'b0);
        run_instr(6'b000000, 6'b010010, 0, 0, 1'b1, 1'b0);
        sw_abort();
        run_instr(6'b111111, 6'd0, 0, 0, 1'b0, 1'b0);
        run_instr(6'b101011, 6'd0, 0, 2, 1'b0, 1'b0);

        for (int t = 0; t < 150; t++) begin
            k  = $urandom_range(0, 9);
            fn = 6'($urandom);
            case (k)
                0: op = 6'b000000;
                1: op = 6'b100011;
                2: op = 6'b101011;
                3: op = 6'b000100;
                4: op = 6'b010101;
                5: op = 6'b011000;
                6: begin op = 6'b000000; fn = 6'b010010; end
                7: begin op = 6'b000000; fn = 6'b100001; end
                8: op = 6'b010011;
                default: op = 6'($urandom);
            endcase
            run_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 3), rb(), rb());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
